// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among three
// requesters (0 = instr fetch, 1 = load/store, 2 = debug/DMA).
// Each transaction runs IDLE -> BUSY -> DONE. Every output is decoded from
// registered state only, so no input reaches an output through logic alone.
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY phase that sees no
// mem_ack within TIMEOUT_CYCLES cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [2:0] req,
  input  logic       mem_ack,
  output logic [2:0] grant,
  output logic [1:0] select,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Reject out-of-range configurations at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;        // index of the current or most recent owner
  logic [1:0] last_ptr_q, last_ptr_d;  // last served requester; it gets lowest priority

  // Returns the next requester index, wrapping from 2 back to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin search: last_ptr+1, last_ptr+2, then last_ptr itself.
  logic [3:0] req_ext;
  logic [1:0] cand1, cand2;
  logic [1:0] win;
  logic       win_valid;

  assign req_ext = {1'b0, req};
  assign cand1   = next_idx(last_ptr_q);
  assign cand2   = next_idx(cand1);

  // Pick the winning requester among those currently asserting req.
  always_comb begin
    // NOTE: give every always_comb output a default before any branch so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    win       = 2'd0;
    win_valid = 1'b0;
    if (req_ext[cand1]) begin
      win       = cand1;
      win_valid = 1'b1;
    end else if (req_ext[cand2]) begin
      win       = cand2;
      win_valid = 1'b1;
    end else if (req_ext[last_ptr_q]) begin
      win       = last_ptr_q;
      win_valid = 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;  // DONE was reached by abort, not by ack
`endif

  // Next-state logic: arbitrate in IDLE, wait for ack (or timeout) in BUSY,
  // retire the transaction in DONE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d = S_BUSY;
          owner_d = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      S_BUSY: begin
        // Owner and select stay frozen; req is not looked at here.
        if (mem_ack) begin
          state_d = S_DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // Ack has priority over the terminal count; only a silent memory aborts.
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        last_ptr_d = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      last_ptr_q <= 2'd2;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = (state_q == S_DONE) && timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Output decode from registered state: grant only in BUSY, done only in DONE.
  assign mem_valid = (state_q == S_BUSY);
  assign busy      = mem_valid;
  assign grant     = mem_valid ? (3'b001 << owner_q) : 3'b000;
  assign select    = mem_valid ? owner_q : 2'b11;
  assign done      = (state_q == S_DONE) ? (3'b001 << owner_q) : 3'b000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by random traffic, all
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int T = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n;
  logic [2:0] req;
  logic       mem_ack;
  logic [2:0] grant;
  logic [1:0] select;
  logic       mem_valid;
  logic [2:0] done;
  logic       busy;
  logic       timeout_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .req         (req),
    .mem_ack     (mem_ack),
    .grant       (grant),
    .select      (select),
    .mem_valid   (mem_valid),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: who holds the port, who is being retired, who went last.
  int m_owner;       // -1 when nobody holds the port
  int m_done_owner;  // -1 unless this cycle is the completion cycle
  int m_last;
  int m_cycles;      // BUSY cycles completed by the current owner
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner      = -1;
    m_done_owner = -1;
    m_last       = 2;
    m_cycles     = 0;
    m_to         = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic a);
    int w;
    if (m_done_owner >= 0) begin
      m_last       = m_done_owner;
      m_done_owner = -1;
      m_to         = 1'b0;
    end else if (m_owner >= 0) begin
      m_cycles++;
      if (a) begin
        m_done_owner = m_owner;
        m_owner      = -1;
        m_to         = 1'b0;
      end else if (TO_EN && m_cycles == T) begin
        m_done_owner = m_owner;
        m_owner      = -1;
        m_to         = 1'b1;
      end
    end else begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner  = w;
        m_cycles = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] e_grant, e_done;
    logic [1:0] e_sel;
    logic [31:0] o;
    e_grant = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e_sel   = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
    e_done  = (m_done_owner >= 0) ? (3'b001 << m_done_owner) : 3'b000;
    check("grant", 32'(grant), 32'(e_grant));
    check("select", 32'(select), 32'(e_sel));
    check("mem_valid", 32'(mem_valid), 32'(m_owner >= 0));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("done", 32'(done), 32'(e_done));
    check("timeout_err", 32'(timeout_err), 32'((m_done_owner >= 0) && m_to));
    o = 32'($countones(grant) <= 1);
    check("grant_onehot", o, 32'd1);
    o = 32'((select != 2'b11) == (grant != 3'b000));
    check("select_vs_grant", o, 32'd1);
  endtask

  // One clock: the model consumes the inputs present at the edge, then the
  // outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (arst_n) model_edge(req, mem_ack);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    arst_n = 1'b1;
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    arst_n  = 1'b0;
    req     = 3'b000;
    mem_ack = 1'b0;
    model_reset();
    #2 check_all();
    @(negedge clk) arst_n = 1'b1;
    #1;

    // Async reset mid-cycle while a grant is live.
    req = 3'b001;
    step();
    check("pre_reset_grant", 32'(grant), 32'h1);
    req = 3'b000;
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_select", 32'(select), 32'h3);
    check("async_rst_grant", 32'(grant), 32'h0);
    check_all();
    step();
    arst_n = 1'b1;

    // Single transaction for requester 1.
    req = 3'b010;
    step();
    check("single_grant", 32'(grant), 32'h2);
    check("single_select", 32'(select), 32'h1);
    step();
    step();
    mem_ack = 1'b1;
    step();
    check("single_done", 32'(done), 32'h2);
    check("single_done_select", 32'(select), 32'h3);
    req     = 3'b000;
    mem_ack = 1'b0;
    step();
    check("single_idle_valid", 32'(mem_valid), 32'h0);

    // Round robin from reset with all three requesting.
    pulse_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_exp[i]));
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
    end
    req = 3'b000;
    step();
    step();

    // Reset mid-BUSY drops the transaction and returns the pointer to 2.
    pulse_reset();
    req = 3'b100;
    step();
    check("midbusy_grant", 32'(grant), 32'h4);
    step();
    req = 3'b000;
    pulse_reset();
    check("midbusy_no_done", 32'(done), 32'h0);
    req = 3'b101;
    step();
    check("after_reset_grant", 32'(grant), 32'h1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    req     = 3'b000;
    step();

    // Silent memory: abort after T BUSY cycles, or wait forever without it.
    req = 3'b100;
    step();
    repeat (4) step();
`ifdef ARB_TIMEOUT_EN
    check("timeout_done", 32'(done), 32'h4);
    check("timeout_err", 32'(timeout_err), 32'h1);
    req = 3'b000;
    step();
`else
    repeat (100) step();
    check("no_timeout_grant", 32'(grant), 32'h4);
    check("no_timeout_err", 32'(timeout_err), 32'h0);
    req     = 3'b000;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
`endif

    // Ack coinciding with the terminal count completes normally.
    req = 3'b100;
    step();
    repeat (3) step();
    mem_ack = 1'b1;
    step();
    check("ack_terminal_done", 32'(done), 32'h4);
    check("ack_terminal_err", 32'(timeout_err), 32'h0);
    mem_ack = 1'b0;
    req     = 3'b000;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req     = 3'($urandom_range(0, 7));
      mem_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
